// File: rtl/conv2_pkg.sv
// Shared constants for the conv2 -> maxpool -> dense slice of the binary CNN.
package conv2_pkg;
   localparam int unsigned CONV2_CH    = 16;
   localparam int unsigned CONV2_OUT_W = 11;
   localparam int unsigned CONV2_OUT_H = 11;
   localparam int unsigned POOL2_W     = 5;
   localparam int unsigned POOL2_H     = 5;

   // Address width for an n-entry array, never narrower than one bit.
   function automatic int unsigned addr_bits(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/pool2_line_buf.sv
// Line buffer of per-column-pair ORs from the even row; sync write, async read.
module pool2_line_buf
   import conv2_pkg::*;
#(
   parameter int unsigned DEPTH = POOL2_W,
   parameter int unsigned CH    = CONV2_CH,
   parameter int unsigned AW    = addr_bits(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [CH-1:0] wdata,
   output logic [CH-1:0] rdata
);

   logic [CH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_comb begin
      rdata = mem[addr];
   end

endmodule

// File: rtl/conv2_maxpool.sv
// Binary 2x2 stride-2 max-pool (per-channel OR) on the conv2 raster stream.
module conv2_maxpool
   import conv2_pkg::*;
#(
   parameter int unsigned WIDTH  = CONV2_OUT_W,
   parameter int unsigned HEIGHT = CONV2_OUT_H,
   parameter int unsigned CH     = CONV2_CH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   input  logic [CH-1:0] conv_in,
   output logic [CH-1:0] pool_out,
   output logic          valid_out,
   output logic          last_out
);

   localparam int unsigned OUT_W = WIDTH / 2;
   localparam int unsigned OUT_H = HEIGHT / 2;
   localparam int unsigned CW    = $clog2(WIDTH + 1);
   localparam int unsigned RW    = $clog2(HEIGHT + 1);
   localparam int unsigned AW    = addr_bits(OUT_W);

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] COL_LIM  = CW'(2 * OUT_W);
   localparam logic [CW-1:0] COL_FIN  = CW'(2 * OUT_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [RW-1:0] ROW_LIM  = RW'(2 * OUT_H);
   localparam logic [RW-1:0] ROW_FIN  = RW'(2 * OUT_H - 1);

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CH-1:0] pair_reg;
   logic [CH-1:0] lb_rdata;
   logic [CH-1:0] pooled;
   logic [CW-1:0] col_half;
   logic [AW-1:0] lb_addr;
   logic          in_cols;
   logic          in_rows;
   logic          lb_we;
   logic          emit;

   // The trailing odd column/row is counted but excluded from both store and emit.
   always_comb begin
      col_half = col >> 1;
      lb_addr  = col_half[AW-1:0];
      in_cols  = (col < COL_LIM);
      in_rows  = (row < ROW_LIM);
      lb_we    = valid_in & ~row[0] & col[0] & in_cols & in_rows;
      emit     = valid_in &  row[0] & col[0] & in_cols & in_rows;
      pooled   = lb_rdata | pair_reg | conv_in;
   end

   pool2_line_buf #(
      .DEPTH (OUT_W),
      .CH    (CH),
      .AW    (AW)
   ) u_line_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (pair_reg | conv_in),
      .rdata (lb_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         pair_reg  <= '0;
         pool_out  <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end else begin
         valid_out <= emit;
         last_out  <= emit & (row == ROW_FIN) & (col == COL_FIN);
         if (emit) begin
            pool_out <= pooled;
         end
         if (valid_in) begin
            if (!col[0]) begin
               pair_reg <= conv_in;
            end
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv2_maxpool.sv
// Scoreboard bench for conv2_maxpool: expected pooled pixels, last flags and emit cycles.
module tb_conv2_maxpool;

   localparam int W = 11;
   localparam int H = 11;

   typedef struct {
      logic [15:0] d;
      logic        l;
      int unsigned cy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [15:0] conv_in;
   logic [15:0] pool_out;
   logic        valid_out;
   logic        last_out;

   logic [15:0] frm [H][W];
   exp_t        sbq [$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   conv2_maxpool #(
      .WIDTH  (W),
      .HEIGHT (H),
      .CH     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .conv_in   (conv_in),
      .pool_out  (pool_out),
      .valid_out (valid_out),
      .last_out  (last_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output monitor: every valid_out pops one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (valid_out === 1'b1) begin
         chk("stray_valid", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("pool_out", 32'(pool_out), 32'(e.d));
            chk("last_out", 32'(last_out), 32'(e.l));
            chk("emit_cycle", cyc, e.cy);
         end
      end else if (last_out !== 1'b0) begin
         chk("last_without_valid", 32'(last_out), 32'd0);
      end
   end

   task automatic fill(input logic [15:0] v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            frm[r][c] = v;
   endtask

   task automatic feed(input int unsigned gmax, input int nbeats);
      int unsigned g;
      exp_t        e;
      int          n;
      n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (n < nbeats) begin
               if (gmax != 0) begin
                  g = $urandom_range(gmax, 0);
                  repeat (g) begin
                     valid_in = 1'b0;
                     conv_in  = 16'($urandom);
                     @(negedge clk);
                  end
               end
               valid_in = 1'b1;
               conv_in  = frm[r][c];
               if ((r % 2 == 1) && (c % 2 == 1) && (r < 10) && (c < 10)) begin
                  e.d  = frm[r-1][c-1] | frm[r-1][c] | frm[r][c-1] | frm[r][c];
                  e.l  = (r == 9) && (c == 9);
                  e.cy = cyc + 1;
                  sbq.push_back(e);
               end
               @(negedge clk);
               n++;
            end
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk(tag, 32'(sbq.size()), 32'd0);
      sbq.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      conv_in  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_pool_out", 32'(pool_out), 32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_last_out", 32'(last_out), 32'd0);

      // All ones, contiguous
      fill(16'hFFFF);
      feed(0, W * H);
      drain("ones_drain");

      // Single channel-1 bit at (0,0), then at (1,1)
      fill(16'h0000);
      frm[0][0] = 16'h0001;
      feed(0, W * H);
      drain("dot00_drain");
      fill(16'h0000);
      frm[1][1] = 16'h0001;
      feed(0, W * H);
      drain("dot11_drain");

      // Ones only in the dropped column and row
      fill(16'h0000);
      for (int i = 0; i < H; i++) frm[i][10] = 16'hFFFF;
      for (int i = 0; i < W; i++) frm[10][i] = 16'hFFFF;
      feed(0, W * H);
      drain("edge_drain");

      // Random frame, contiguous then with gaps
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            frm[r][c] = 16'($urandom);
      feed(0, W * H);
      drain("rand_contig_drain");
      feed(3, W * H);
      drain("rand_gap_drain");

      // Abort mid-frame: reset lands on beat 60 (an emission beat) and wins
      fill(16'hFFFF);
      feed(0, 60);
      valid_in = 1'b1;
      conv_in  = frm[5][5];
      rst      = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      valid_in = 1'b0;
      chk("midrst_valid_out", 32'(valid_out), 32'd0);
      chk("midrst_pool_out", 32'(pool_out), 32'd0);
      drain("midrst_drain");
      feed(0, W * H);
      drain("after_rst_drain");

      // Three back-to-back frames, distinct contents
      for (int k = 0; k < 3; k++) begin
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               frm[r][c] = 16'($urandom);
         feed(0, W * H);
         valid_in = 1'b1;
      end
      valid_in = 1'b0;
      drain("b2b_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
